// File: rtl/wq_descriptor_dispatcher.sv
// Pops work-queue entries and replays each as four DCS register writes (W0..W3, W3 = go).
// Pop to first bus word is 1 cycle; each word holds while the selected WaitRequest is high.
module wq_descriptor_dispatcher #(
  parameter logic [7:0] REG_BASE = 8'h00,
  parameter logic [4:0] OP_READ  = 5'd1,
  parameter logic [4:0] OP_WRITE = 5'd2,
  parameter int         CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifoEmpty,
  input  logic [115:0]     fifoData,
  output logic             fifoPop,
  output logic             RdDCSChipSelect_o,
  output logic             RdDCSWrite_o,
  output logic             RdDCSRead_o,
  output logic [7:0]       RdDCSAddress_o,
  output logic [31:0]      RdDCSWriteData_o,
  output logic [3:0]       RdDCSByteEnable_o,
  input  logic             RdDCSWaitRequest_i,
  output logic             WrDCSChipSelect_o,
  output logic             WrDCSWrite_o,
  output logic             WrDCSRead_o,
  output logic [7:0]       WrDCSAddress_o,
  output logic [31:0]      WrDCSWriteData_o,
  output logic [3:0]       WrDCSByteEnable_o,
  input  logic             WrDCSWaitRequest_i,
  output logic             busy,
  output logic [CNT_W-1:0] dispatchCount,
  output logic [CNT_W-1:0] dropCount
);

  typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;

  state_t       state, stateNext;
  logic [110:0] entry;
  logic         toWrite;
  logic [4:0]   headOp;
  logic [2:0]   headNum;
  logic         headValid;
  logic         active, selWait, xferDone;
  logic         tryPop, dispatchDone, dropInc;
  logic [31:0]  word;
  logic [1:0]   wordIdx;
  logic [7:0]   wordAddr;
  logic         rdSel, wrSel;

  assign headOp    = fifoData[115:111];
  assign headNum   = fifoData[110:108];
  assign headValid = ((headOp == OP_READ) || (headOp == OP_WRITE)) && (headNum != 3'd0);

  assign active   = (state != IDLE);
  assign selWait  = toWrite ? WrDCSWaitRequest_i : RdDCSWaitRequest_i;
  assign xferDone = active && !selWait;

  // W3 completion re-evaluates the pop condition so entries stream without a bubble.
  always_comb begin
    stateNext    = state;
    tryPop       = 1'b0;
    fifoPop      = 1'b0;
    dispatchDone = 1'b0;
    dropInc      = 1'b0;
    case (state)
      IDLE: tryPop = 1'b1;
      W0:   if (xferDone) stateNext = W1;
      W1:   if (xferDone) stateNext = W2;
      W2:   if (xferDone) stateNext = W3;
      W3: begin
        if (xferDone) begin
          dispatchDone = 1'b1;
          stateNext    = IDLE;
          tryPop       = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (tryPop && reset && enable && !fifoEmpty) begin
      fifoPop = 1'b1;
      if (headValid) stateNext = W0;
      else           dropInc   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      entry         <= '0;
      toWrite       <= 1'b0;
      dispatchCount <= '0;
      dropCount     <= '0;
    end else begin
      state <= stateNext;
      if (fifoPop) begin
        entry   <= fifoData[110:0];
        toWrite <= (headOp == OP_WRITE);
      end
      if (dispatchDone) dispatchCount <= dispatchCount + CNT_W'(1);
      if (dropInc)      dropCount     <= dropCount + CNT_W'(1);
    end
  end

  always_comb begin
    word    = '0;
    wordIdx = 2'd0;
    case (state)
      W0: word = entry[31:0];
      W1: begin word = entry[63:32]; wordIdx = 2'd1; end
      W2: begin word = {5'd0, entry[110:108], entry[107:100], 7'd0, entry[99:91]}; wordIdx = 2'd2; end
      W3: begin word = {5'd0, entry[90:64]}; wordIdx = 2'd3; end
      default: ;
    endcase
  end

  assign wordAddr = REG_BASE + {4'd0, wordIdx, 2'b00};
  assign rdSel    = active && !toWrite;
  assign wrSel    = active && toWrite;

  assign RdDCSChipSelect_o = rdSel;
  assign RdDCSWrite_o      = rdSel;
  assign RdDCSRead_o       = 1'b0;
  assign RdDCSAddress_o    = rdSel ? wordAddr : 8'h00;
  assign RdDCSWriteData_o  = rdSel ? word : 32'h0;
  assign RdDCSByteEnable_o = rdSel ? 4'hF : 4'h0;

  assign WrDCSChipSelect_o = wrSel;
  assign WrDCSWrite_o      = wrSel;
  assign WrDCSRead_o       = 1'b0;
  assign WrDCSAddress_o    = wrSel ? wordAddr : 8'h00;
  assign WrDCSWriteData_o  = wrSel ? word : 32'h0;
  assign WrDCSByteEnable_o = wrSel ? 4'hF : 4'h0;

  assign busy = active;

endmodule

// File: tb/tb_wq_descriptor_dispatcher.sv
// Directed bench for wq_descriptor_dispatcher: show-ahead FIFO model, bus transfer log, per-scenario checks.
module tb_wq_descriptor_dispatcher;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         fifoEmpty;
  logic [115:0] fifoData;
  logic         fifoPop;
  logic         RdDCSChipSelect_o, RdDCSWrite_o, RdDCSRead_o;
  logic [7:0]   RdDCSAddress_o;
  logic [31:0]  RdDCSWriteData_o;
  logic [3:0]   RdDCSByteEnable_o;
  logic         RdDCSWaitRequest_i = 1'b0;
  logic         WrDCSChipSelect_o, WrDCSWrite_o, WrDCSRead_o;
  logic [7:0]   WrDCSAddress_o;
  logic [31:0]  WrDCSWriteData_o;
  logic [3:0]   WrDCSByteEnable_o;
  logic         WrDCSWaitRequest_i = 1'b0;
  logic         busy;
  logic [15:0]  dispatchCount, dropCount;

  int checks = 0;
  int failures = 0;

  wq_descriptor_dispatcher dut (
    .clock(clock), .reset(reset), .enable(enable),
    .fifoEmpty(fifoEmpty), .fifoData(fifoData), .fifoPop(fifoPop),
    .RdDCSChipSelect_o(RdDCSChipSelect_o), .RdDCSWrite_o(RdDCSWrite_o), .RdDCSRead_o(RdDCSRead_o),
    .RdDCSAddress_o(RdDCSAddress_o), .RdDCSWriteData_o(RdDCSWriteData_o),
    .RdDCSByteEnable_o(RdDCSByteEnable_o), .RdDCSWaitRequest_i(RdDCSWaitRequest_i),
    .WrDCSChipSelect_o(WrDCSChipSelect_o), .WrDCSWrite_o(WrDCSWrite_o), .WrDCSRead_o(WrDCSRead_o),
    .WrDCSAddress_o(WrDCSAddress_o), .WrDCSWriteData_o(WrDCSWriteData_o),
    .WrDCSByteEnable_o(WrDCSByteEnable_o), .WrDCSWaitRequest_i(WrDCSWaitRequest_i),
    .busy(busy), .dispatchCount(dispatchCount), .dropCount(dropCount)
  );

  always #5 clock = ~clock;

  // show-ahead FIFO model
  logic [115:0] fmem [0:31];
  int rdPtr = 0, wrPtr = 0, popCount = 0, popEmptyErr = 0;
  assign fifoEmpty = (rdPtr == wrPtr);
  assign fifoData  = fmem[rdPtr % 32];

  always @(posedge clock) begin
    if (fifoPop) begin
      if (fifoEmpty) popEmptyErr <= popEmptyErr + 1;
      else           rdPtr <= rdPtr + 1;
      popCount <= popCount + 1;
    end
  end

  // completed bus transfers, both ports, with cycle stamp
  typedef struct {
    bit          isWr;
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } xfer_t;
  xfer_t xlog[$];
  int cyc = 0, rdAny = 0, wrAny = 0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (RdDCSChipSelect_o && RdDCSWrite_o && !RdDCSWaitRequest_i)
      xlog.push_back('{1'b0, RdDCSAddress_o, RdDCSWriteData_o, cyc});
    if (WrDCSChipSelect_o && WrDCSWrite_o && !WrDCSWaitRequest_i)
      xlog.push_back('{1'b1, WrDCSAddress_o, WrDCSWriteData_o, cyc});
    if ({RdDCSChipSelect_o, RdDCSWrite_o, RdDCSRead_o, RdDCSAddress_o, RdDCSWriteData_o, RdDCSByteEnable_o} != '0)
      rdAny <= rdAny + 1;
    if ({WrDCSChipSelect_o, WrDCSWrite_o, WrDCSRead_o, WrDCSAddress_o, WrDCSWriteData_o, WrDCSByteEnable_o} != '0)
      wrAny <= wrAny + 1;
  end

  function automatic logic [115:0] mkEntry(input logic [4:0] op, input logic [2:0] num, input logic [7:0] tid,
                                           input logic [8:0] l0, input logic [8:0] l1, input logic [8:0] l2,
                                           input logic [8:0] l3, input logic [63:0] a);
    return {op, num, tid, l0, l1, l2, l3, a};
  endfunction

  task automatic push(input logic [115:0] e);
    fmem[wrPtr % 32] = e;
    wrPtr++;
  endtask

  task automatic waitDispatch(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clock);
      if (dispatchCount == 16'(target)) ok = 1;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({fifoPop, busy, RdDCSChipSelect_o, RdDCSWrite_o, RdDCSRead_o, RdDCSAddress_o, RdDCSWriteData_o,
         RdDCSByteEnable_o, WrDCSChipSelect_o, WrDCSWrite_o, WrDCSRead_o, WrDCSAddress_o,
         WrDCSWriteData_o, WrDCSByteEnable_o} !== '0) begin
      failures++; $display("FAIL reset_outputs: some output nonzero, required all 0");
    end
    checks++;
    if (dispatchCount !== 16'd0 || dropCount !== 16'd0) begin
      failures++; $display("FAIL reset_counters: got %0d/%0d required 0/0", dispatchCount, dropCount);
    end
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_read_dispatch;
    logic [31:0] expD [4];
    bit ok;
    int popBase = popCount, wrBase = wrAny;
    expD[0] = 32'h89ABCDEF; expD[1] = 32'h01234567; expD[2] = 32'h025A01FF; expD[3] = 32'h000D5555;
    xlog.delete();
    push(mkEntry(5'd1, 3'd2, 8'h5A, 9'h1FF, 9'h003, 9'h0AA, 9'h155, 64'h0123_4567_89AB_CDEF));
    enable = 1'b1;
    waitDispatch(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL t1_timeout: dispatchCount=%0d required 1", dispatchCount); end
    @(negedge clock);
    checks++;
    if (xlog.size() !== 4) begin failures++; $display("FAIL t1_nwrites: got %0d required 4", xlog.size()); end
    for (int i = 0; i < 4 && i < xlog.size(); i++) begin
      checks++;
      if (xlog[i].isWr !== 1'b0 || xlog[i].addr !== 8'(4 * i) || xlog[i].data !== expD[i]) begin
        failures++;
        $display("FAIL t1_word%0d: got wr=%0d @%h=%h required rd @%h=%h", i, xlog[i].isWr,
                 xlog[i].addr, xlog[i].data, 8'(4 * i), expD[i]);
      end
    end
    checks++;
    if (wrAny !== wrBase) begin failures++; $display("FAIL t1_wr_idle: WrDCS active %0d cycles required 0", wrAny - wrBase); end
    checks++;
    if (popCount - popBase !== 1) begin failures++; $display("FAIL t1_pops: got %0d required 1", popCount - popBase); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL t1_busy: got %0d required 0", busy); end
  endtask

  task automatic test_waitstate;
    logic [31:0] expD [4];
    bit seen = 0, ok;
    int rdBase = rdAny;
    expD[0] = 32'h76543210; expD[1] = 32'hFEDCBA98; expD[2] = 32'h05C30010; expD[3] = 32'h0003FE01;
    xlog.delete();
    push(mkEntry(5'd2, 3'd5, 8'hC3, 9'h010, 9'h000, 9'h1FF, 9'h001, 64'hFEDC_BA98_7654_3210));
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (WrDCSChipSelect_o && WrDCSAddress_o == 8'h04) seen = 1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL t2_w1_seen: W1 never presented, required within 50 cycles"); end
    WrDCSWaitRequest_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (WrDCSChipSelect_o !== 1'b1 || WrDCSAddress_o !== 8'h04 || WrDCSWriteData_o !== 32'hFEDCBA98) begin
        failures++;
        $display("FAIL t2_hold%0d: got cs=%0d @%h=%h required cs=1 @04=fedcba98", k,
                 WrDCSChipSelect_o, WrDCSAddress_o, WrDCSWriteData_o);
      end
    end
    WrDCSWaitRequest_i = 1'b0;
    waitDispatch(2, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL t2_timeout: dispatchCount=%0d required 2", dispatchCount); end
    checks++;
    if (xlog.size() !== 4) begin failures++; $display("FAIL t2_nwrites: got %0d required 4", xlog.size()); end
    for (int i = 0; i < 4 && i < xlog.size(); i++) begin
      checks++;
      if (xlog[i].isWr !== 1'b1 || xlog[i].addr !== 8'(4 * i) || xlog[i].data !== expD[i]) begin
        failures++;
        $display("FAIL t2_word%0d: got wr=%0d @%h=%h required wr @%h=%h", i, xlog[i].isWr,
                 xlog[i].addr, xlog[i].data, 8'(4 * i), expD[i]);
      end
    end
    checks++;
    if (rdAny !== rdBase) begin failures++; $display("FAIL t2_rd_idle: RdDCS active %0d cycles required 0", rdAny - rdBase); end
  endtask

  task automatic test_drop;
    bit ok;
    int popBase = popCount;
    enable = 1'b0;
    xlog.delete();
    push(mkEntry(5'd7, 3'd1, 8'h00, 9'h0, 9'h0, 9'h0, 9'h0, 64'h0));
    push(mkEntry(5'd1, 3'd0, 8'h00, 9'h0, 9'h0, 9'h0, 9'h0, 64'h0));
    push(mkEntry(5'd2, 3'd1, 8'h11, 9'h001, 9'h0, 9'h0, 9'h0, 64'h40));
    @(negedge clock); enable = 1'b1;
    waitDispatch(3, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL t3_timeout: dispatchCount=%0d required 3", dispatchCount); end
    checks++;
    if (dropCount !== 16'd2) begin failures++; $display("FAIL t3_drops: got %0d required 2", dropCount); end
    checks++;
    if (popCount - popBase !== 3) begin failures++; $display("FAIL t3_pops: got %0d required 3", popCount - popBase); end
    checks++;
    if (xlog.size() !== 4) begin failures++; $display("FAIL t3_nwrites: got %0d required 4", xlog.size()); end
    else begin
      checks++;
      if (!xlog[0].isWr || xlog[0].data !== 32'h00000040 || xlog[2].data !== 32'h01110001) begin
        failures++;
        $display("FAIL t3_words: got wr=%0d W0=%h W2=%h required wr=1 W0=00000040 W2=01110001",
                 xlog[0].isWr, xlog[0].data, xlog[2].data);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int popBase = popCount;
    enable = 1'b0;
    xlog.delete();
    push(mkEntry(5'd1, 3'd1, 8'h01, 9'h0, 9'h0, 9'h0, 9'h0, 64'h0000_0001_1000_0000));
    push(mkEntry(5'd2, 3'd1, 8'h02, 9'h0, 9'h0, 9'h0, 9'h0, 64'h0000_0002_2000_0000));
    push(mkEntry(5'd1, 3'd1, 8'h03, 9'h0, 9'h0, 9'h0, 9'h0, 64'h0000_0003_3000_0000));
    @(negedge clock); enable = 1'b1;
    waitDispatch(6, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL t4_timeout: dispatchCount=%0d required 6", dispatchCount); end
    checks++;
    if (xlog.size() !== 12) begin failures++; $display("FAIL t4_nwrites: got %0d required 12", xlog.size()); end
    else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (xlog[i].cyc !== xlog[0].cyc + i || xlog[i].addr !== 8'(4 * (i % 4)) ||
            xlog[i].isWr !== ((i / 4) == 1)) begin
          failures++;
          $display("FAIL t4_seq%0d: got cyc+%0d wr=%0d @%h required cyc+%0d wr=%0d @%h", i,
                   xlog[i].cyc - xlog[0].cyc, xlog[i].isWr, xlog[i].addr, i, ((i / 4) == 1), 8'(4 * (i % 4)));
        end
      end
      checks++;
      if (xlog[0].data !== 32'h10000000 || xlog[4].data !== 32'h20000000 || xlog[9].data !== 32'h00000003) begin
        failures++;
        $display("FAIL t4_data: got %h %h %h required 10000000 20000000 00000003",
                 xlog[0].data, xlog[4].data, xlog[9].data);
      end
    end
    checks++;
    if (popCount - popBase !== 3) begin failures++; $display("FAIL t4_pops: got %0d required 3", popCount - popBase); end
  endtask

  task automatic test_reset_mid_entry;
    bit seen = 0;
    push(mkEntry(5'd1, 3'd3, 8'h77, 9'h0, 9'h0, 9'h0, 9'h0, 64'hAAAA_BBBB_CCCC_DDDD));
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (RdDCSChipSelect_o && RdDCSAddress_o == 8'h08) seen = 1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL t5_w2_seen: W2 never presented, required within 50 cycles"); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({fifoPop, busy, RdDCSChipSelect_o, RdDCSWrite_o, RdDCSAddress_o, RdDCSWriteData_o, RdDCSByteEnable_o,
         WrDCSChipSelect_o, WrDCSWrite_o, WrDCSAddress_o, WrDCSWriteData_o, WrDCSByteEnable_o} !== '0) begin
      failures++;
      $display("FAIL t5_async_clear: got rdcs=%0d @%h=%h busy=%0d required all 0",
               RdDCSChipSelect_o, RdDCSAddress_o, RdDCSWriteData_o, busy);
    end
    checks++;
    if (dispatchCount !== 16'd0 || dropCount !== 16'd0) begin
      failures++; $display("FAIL t5_counters: got %0d/%0d required 0/0", dispatchCount, dropCount);
    end
    xlog.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    checks++;
    if (xlog.size() !== 0 || busy !== 1'b0 || dispatchCount !== 16'd0) begin
      failures++;
      $display("FAIL t5_quiet: got writes=%0d busy=%0d dispatch=%0d required 0/0/0", xlog.size(), busy, dispatchCount);
    end
  endtask

  task automatic test_enable_drop;
    bit seen = 0, ok;
    int popBase = popCount;
    enable = 1'b0;
    xlog.delete();
    push(mkEntry(5'd2, 3'd1, 8'h21, 9'h0, 9'h0, 9'h0, 9'h0, 64'h0000_0000_0000_1000));
    push(mkEntry(5'd1, 3'd1, 8'h22, 9'h0, 9'h0, 9'h0, 9'h0, 64'h0000_0000_0000_2000));
    @(negedge clock); enable = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (WrDCSChipSelect_o && WrDCSAddress_o == 8'h04) seen = 1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL t6_w1_seen: W1 never presented, required within 50 cycles"); end
    enable = 1'b0;
    repeat (20) @(negedge clock);
    checks++;
    if (dispatchCount !== 16'd1 || xlog.size() !== 4) begin
      failures++; $display("FAIL t6_finish: got dispatch=%0d writes=%0d required 1/4", dispatchCount, xlog.size());
    end
    checks++;
    if (popCount - popBase !== 1 || fifoEmpty !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL t6_no_pop: got pops=%0d empty=%0d busy=%0d required 1/0/0", popCount - popBase, fifoEmpty, busy);
    end
    enable = 1'b1;
    waitDispatch(2, ok);
    checks++;
    if (!ok || xlog.size() !== 8 || fifoEmpty !== 1'b1) begin
      failures++;
      $display("FAIL t6_resume: got dispatch=%0d writes=%0d empty=%0d required 2/8/1", dispatchCount, xlog.size(), fifoEmpty);
    end
    else begin
      checks++;
      if (xlog[4].isWr !== 1'b0 || xlog[4].data !== 32'h00002000) begin
        failures++; $display("FAIL t6_second: got wr=%0d W0=%h required rd W0=00002000", xlog[4].isWr, xlog[4].data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_dispatch();
    test_waitstate();
    test_drop();
    test_back_to_back();
    test_reset_mid_entry();
    test_enable_drop();
    checks++;
    if (popEmptyErr !== 0) begin failures++; $display("FAIL pop_when_empty: got %0d required 0", popEmptyErr); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
